tia_motion_registers_top: RTL and testbench
===========================================

# tia_motion_registers_top

Horizontal-motion (HMOVE) unit of the TIA: five 4-bit signed motion registers (P0, P1, M0, M1, BL) plus the two-phase horizontal clock generator. Each object's register is written from data bits D7..D4. An HMOVE strobe then makes the block emit a burst of active-low extra-clock pulses per object, consumed by the object position counters. The unit sits between the TIA register-write decode and the object counters.

## Interface
- No parameters.
- clk  in  1  color clock; all state on rising edge
- r  in  1  reset, asynchronous, active-high
- d4, d5, d6, d7  in  1 each  write data; d7 is the sign bit (HM value = {d7,d6,d5,d4})
- p0hm, p1hm, m0hm, m1hm, blhm  in  1 each  write strobes for the five motion registers
- hmclr  in  1  clear all motion registers
- sec  in  1  HMOVE start request
- hphi1, hphi2  out  1 each  horizontal clock phases, non-overlapping
- rsynl  out  1  reset-latched status
- p0ec_bar, p1ec_bar, m0ec_bar, m1ec_bar, blec_bar  out  1 each  extra-clock pulses, active-low

## Operation
- Phase divider: 2-bit counter `ph` increments every clk and wraps 3→0.
  - hphi1 = (ph==0); hphi2 = (ph==2).
  - One "step" = 4 clk.
- rsynl asserts asynchronously with r. It deasserts on the first clk where hphi2 is high after r is released.
- Register write:
  - At each rising clk where strobe xxhm=1, load {d7,d6,d5,d4} into that object's register.
  - Multiple strobes may be high at once; every selected register loads.
- hmclr=1 at a rising clk forces all five registers to 0000. hmclr wins over a simultaneous strobe.
- Extra-clock count per object: N = HM XOR 4'b1000, range 0..15. Examples: 0111→15, 0000→8, 1000→0, 1100→4.
- HMOVE sequence:
  - A rising edge of sec (sec=1 and previous sample 0) arms the sequencer.
  - At the next hphi1 step, step index k=0 begins; steps 0..15 follow.
  - During the hphi1 clk of step k, xxec_bar=0 iff k < N for that object's current register value. Otherwise it stays 1.
  - After step 15 the sequencer goes idle.
- Registers are compared live, so writes during a sequence affect the remaining steps.
- Holding sec high for several clocks starts exactly one sequence.
- sec rising during an active sequence: see Configuration.

## Timing
- Reset values:
  - ph=0, hphi1=0, hphi2=0, rsynl=1.
  - All registers 0000.
  - Sequencer idle.
  - All xxec_bar=1.
- Phase, sequencer and register state are registered. hphi1, hphi2 and ec outputs are decoded from registered state, with no combinational path from inputs.
- Each extra-clock pulse is low for exactly one clk.
- Pulses are spaced 4 clk apart.
- The burst for one object lasts at most 16 steps (64 clk) after the arming edge plus ≤4 clk phase alignment.
- Write latency: a value loaded at edge t governs pulses from edge t+1.
- Reset mid-sequence aborts immediately; outputs return to their reset values.

## Configuration
- TIA_HMOVE_RETRIGGER_EN
  - Defined: a sec rising edge during an active sequence restarts at step 0 on the next hphi1.
  - Undefined: such an edge is ignored until idle.

## Structure
- Shared package tia_motion_pkg:
  - object index enum (P0, P1, M0, M1, BL)
  - HM_W=4, STEPS=16, PHASES=4
  - HM sign-flip constant 4'b1000
- One sub-module, tia_biphase_clock (clk, r → hphi1, hphi2, rsynl).
- Five identical register/compare slices are generated inline.

## Test plan
- Reset released, free-run 8 clk → hphi1 high at ph 0, hphi2 at ph 2, never both high; rsynl falls at first hphi2.
- Per line of 228 clk:
  - write P0=0111, P1=0000, M0=0100, M1=1100, BL=0010 on cycles 0..4
  - sec high cycles 9..12
  - expected low-cycle counts 15, 8, 12, 4, 10
- Same bench with 1000, 1010, 1111, 0011, 1011 → counts 0, 2, 7, 11, 3; with 0101, 0001, 1110, 1101, 1001 → 13, 9, 6, 5, 1.
- hmclr high cycles 0..8, then sec → every object counts 8.
- sec held 20 clk → one burst only.
- Second sec edge mid-burst → count follows the macro setting.
- Assert r at step 5 → all ec_bar return high at once.

Source files
------------

// File: rtl/tia_motion_pkg.sv
// Shared types and constants for the TIA horizontal-motion unit.
// Optional feature macro used by the top: TIA_HMOVE_RETRIGGER_EN.
package tia_motion_pkg;

    typedef enum logic [2:0] {
        OBJ_P0 = 3'd0,
        OBJ_P1 = 3'd1,
        OBJ_M0 = 3'd2,
        OBJ_M1 = 3'd3,
        OBJ_BL = 3'd4
    } obj_e;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

    localparam int HM_W    = 4;
    localparam int STEPS   = 16;
    localparam int PHASES  = 4;
    localparam int NUM_OBJ = 5;
    localparam int STEP_W  = $clog2(STEPS);
    localparam int PH_W    = $clog2(PHASES);

    localparam logic [HM_W-1:0]   HM_FLIP   = 4'b1000;
    localparam logic [STEP_W-1:0] LAST_STEP = 4'(STEPS - 1);

    // Signed motion value mapped to the number of extra clocks (0..15).
    function automatic logic [HM_W-1:0] hm_count(input logic [HM_W-1:0] hm);
        return hm ^ HM_FLIP;
    endfunction

endpackage

// File: rtl/tia_motion_registers_top_tia_biphase_clock.sv
// Two-phase horizontal clock: free-running /4 divider with registered
// phase strobes and the reset-sync status flag.
module tia_biphase_clock
    import tia_motion_pkg::*;
(
    input  logic clk,
    input  logic r,
    output logic hphi1,
    output logic hphi2,
    output logic rsynl
);

    logic [PH_W-1:0] r_ph;
    logic            r_hphi1;
    logic            r_hphi2;
    logic            r_rsynl;

    // Phase counter; strobes are registered so they track ph==0 / ph==2
    // while staying low during reset.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_ph    <= 2'd0;
            r_hphi1 <= 1'b0;
            r_hphi2 <= 1'b0;
            r_rsynl <= 1'b1;
        end else begin
            r_ph    <= r_ph + 2'd1;
            r_hphi1 <= (r_ph == 2'd3);
            r_hphi2 <= (r_ph == 2'd1);
            if (r_ph == 2'd1) begin
                r_rsynl <= 1'b0;
            end
        end
    end

    assign hphi1 = r_hphi1;
    assign hphi2 = r_hphi2;
    assign rsynl = r_rsynl;

endmodule

// File: rtl/tia_motion_registers_top.sv
// HMOVE unit: five motion registers, the 16-step extra-clock sequencer and
// the two-phase clock. TIA_HMOVE_RETRIGGER_EN lets a new sec edge restart
// an active sequence; by default such an edge is ignored.
module tia_motion_registers_top
    import tia_motion_pkg::*;
(
    input  logic clk,
    input  logic r,
    input  logic d4,
    input  logic d5,
    input  logic d6,
    input  logic d7,
    input  logic p0hm,
    input  logic p1hm,
    input  logic m0hm,
    input  logic m1hm,
    input  logic blhm,
    input  logic hmclr,
    input  logic sec,
    output logic hphi1,
    output logic hphi2,
    output logic rsynl,
    output logic p0ec_bar,
    output logic p1ec_bar,
    output logic m0ec_bar,
    output logic m1ec_bar,
    output logic blec_bar
);

    logic [HM_W-1:0]    w_hm_data;
    logic [NUM_OBJ-1:0] w_wr;
    logic [NUM_OBJ-1:0] w_ec_bar;
    logic               w_hphi2;

    assign w_hm_data = {d7, d6, d5, d4};
    assign w_wr[int'(OBJ_P0)] = p0hm;
    assign w_wr[int'(OBJ_P1)] = p1hm;
    assign w_wr[int'(OBJ_M0)] = m0hm;
    assign w_wr[int'(OBJ_M1)] = m1hm;
    assign w_wr[int'(OBJ_BL)] = blhm;

    tia_biphase_clock u_clk (
        .clk   (clk),
        .r     (r),
        .hphi1 (hphi1),
        .hphi2 (w_hphi2),
        .rsynl (rsynl)
    );
    assign hphi2 = w_hphi2;

    seq_state_e          r_state;
    seq_state_e          w_state_n;
    logic [STEP_W-1:0]   r_step;
    logic [STEP_W-1:0]   w_step_n;
    logic                r_sec_d;
    logic                r_armed;
    logic                r_ph3;
    logic                w_sec_rise;
    logic                w_arm_req;
    logic                w_clear_arm;
    logic                w_emit;

    assign w_sec_rise = sec & ~r_sec_d;
`ifdef TIA_HMOVE_RETRIGGER_EN
    assign w_arm_req = w_sec_rise;
`else
    assign w_arm_req = w_sec_rise & (r_state == SEQ_IDLE);
`endif

    // Sequencer state; r_ph3 marks the edge that enters an hphi1 cycle.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_state <= SEQ_IDLE;
            r_step  <= 4'd0;
            r_sec_d <= 1'b0;
            r_armed <= 1'b0;
            r_ph3   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_step  <= w_step_n;
            r_sec_d <= sec;
            r_armed <= w_arm_req | (r_armed & ~w_clear_arm);
            r_ph3   <= w_hphi2;
        end
    end

    // Step advance happens only on hphi1 entry; a pending arm restarts at 0.
    always_comb begin
        w_state_n   = r_state;
        w_step_n    = r_step;
        w_clear_arm = 1'b0;
        if (r_ph3) begin
            case (r_state)
                SEQ_IDLE: begin
                    if (r_armed) begin
                        w_state_n   = SEQ_RUN;
                        w_step_n    = 4'd0;
                        w_clear_arm = 1'b1;
                    end else begin
                        w_state_n = SEQ_IDLE;
                    end
                end
                SEQ_RUN: begin
                    if (r_armed) begin
                        w_step_n    = 4'd0;
                        w_clear_arm = 1'b1;
                    end else if (r_step == LAST_STEP) begin
                        w_state_n = SEQ_IDLE;
                    end else begin
                        w_step_n = r_step + 4'd1;
                    end
                end
                default: begin
                    w_state_n = SEQ_IDLE;
                    w_step_n  = 4'd0;
                end
            endcase
        end else begin
            w_state_n = r_state;
        end
    end

    assign w_emit = r_ph3 & (w_state_n == SEQ_RUN);

    genvar g;
    generate
        for (g = 0; g < NUM_OBJ; g++) begin : g_slice
            logic [HM_W-1:0] r_hm;
            logic            r_ec_bar;

            // Motion register: clear has priority over a write strobe.
            always_ff @(posedge clk or posedge r) begin
                if (r) begin
                    r_hm <= 4'd0;
                end else if (hmclr) begin
                    r_hm <= 4'd0;
                end else if (w_wr[g]) begin
                    r_hm <= w_hm_data;
                end
            end

            // Live compare against the current register value.
            always_ff @(posedge clk or posedge r) begin
                if (r) begin
                    r_ec_bar <= 1'b1;
                end else begin
                    r_ec_bar <= ~(w_emit && (w_step_n < hm_count(r_hm)));
                end
            end

            assign w_ec_bar[g] = r_ec_bar;
        end
    endgenerate

    assign p0ec_bar = w_ec_bar[int'(OBJ_P0)];
    assign p1ec_bar = w_ec_bar[int'(OBJ_P1)];
    assign m0ec_bar = w_ec_bar[int'(OBJ_M0)];
    assign m1ec_bar = w_ec_bar[int'(OBJ_M1)];
    assign blec_bar = w_ec_bar[int'(OBJ_BL)];

endmodule

// File: tb/tb_tia_motion_registers_top.sv
// Directed + randomized bench for the HMOVE unit; extra-clock counts are
// predicted from the signed motion values.
module tb_tia_motion_registers_top;

    logic clk = 1'b0;
    logic r   = 1'b1;
    logic d4 = 1'b0, d5 = 1'b0, d6 = 1'b0, d7 = 1'b0;
    logic p0hm = 1'b0, p1hm = 1'b0, m0hm = 1'b0, m1hm = 1'b0, blhm = 1'b0;
    logic hmclr = 1'b0, sec = 1'b0;
    logic hphi1, hphi2, rsynl;
    logic p0ec_bar, p1ec_bar, m0ec_bar, m1ec_bar, blec_bar;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int low_cnt[5];
    int last_low[5];

    tia_motion_registers_top dut (
        .clk(clk), .r(r),
        .d4(d4), .d5(d5), .d6(d6), .d7(d7),
        .p0hm(p0hm), .p1hm(p1hm), .m0hm(m0hm), .m1hm(m1hm), .blhm(blhm),
        .hmclr(hmclr), .sec(sec),
        .hphi1(hphi1), .hphi2(hphi2), .rsynl(rsynl),
        .p0ec_bar(p0ec_bar), .p1ec_bar(p1ec_bar), .m0ec_bar(m0ec_bar),
        .m1ec_bar(m1ec_bar), .blec_bar(blec_bar)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic logic [4:0] ec_vec();
        return {blec_bar, m1ec_bar, m0ec_bar, p1ec_bar, p0ec_bar};
    endfunction

    // Extra clocks for a signed motion value: -8..+7 maps to 0..15.
    function automatic int model_count(input logic [3:0] hm);
        return int'($signed(hm)) + 8;
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < 5; i++) begin
            low_cnt[i]  = 0;
            last_low[i] = -1;
        end
    endtask

    task automatic tick();
        logic [4:0] ec;
        @(posedge clk);
        #1;
        cyc++;
        ec = ec_vec();
        chk("phase_excl", int'(hphi1 & hphi2), 0);
        for (int i = 0; i < 5; i++) begin
            if (ec[i] == 1'b0) begin
                low_cnt[i]++;
                chk("ec_on_hphi1", int'(hphi1), 1);
                if (last_low[i] >= 0) chk("ec_spacing", (cyc - last_low[i]) % 4, 0);
                last_low[i] = cyc;
            end
        end
    endtask

    task automatic set_inputs(input int c, input logic [19:0] hmv, input int clr_len,
                              input int s_on, input int s_off, input int s2_on, input int s2_off);
        logic [3:0] v;
        {p0hm, p1hm, m0hm, m1hm, blhm} = 5'b00000;
        if (c < 5) begin
            v = hmv[c*4 +: 4];
            {d7, d6, d5, d4} = v;
            case (c)
                0: p0hm = 1'b1;
                1: p1hm = 1'b1;
                2: m0hm = 1'b1;
                3: m1hm = 1'b1;
                default: blhm = 1'b1;
            endcase
        end else begin
            {d7, d6, d5, d4} = 4'($urandom_range(15, 0));
        end
        hmclr = (c < clr_len);
        sec   = (c >= s_on && c <= s_off) || (c >= s2_on && c <= s2_off);
    endtask

    // One 228-clock line; mult scales the expected count (retrigger case).
    task automatic run_line(input string tag, input logic [19:0] hmv, input int clr_len,
                            input int s_on, input int s_off, input int s2_on, input int s2_off,
                            input int mult);
        int exp_n;
        clear_counts();
        for (int c = 0; c < 228; c++) begin
            set_inputs(c, hmv, clr_len, s_on, s_off, s2_on, s2_off);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            exp_n = (clr_len > 4) ? 8 : model_count(hmv[i*4 +: 4]);
            chk($sformatf("%s_obj%0d", tag, i), low_cnt[i], exp_n * mult);
        end
    endtask

    initial begin
        logic [19:0] hmv;
        bit hit;
        int s_on, s_len;

        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hphi1", int'(hphi1), 0);
        chk("rst_hphi2", int'(hphi2), 0);
        chk("rst_rsynl", int'(rsynl), 1);
        chk("rst_ec", int'(ec_vec()), 31);
        r = 1'b0;

        for (int n = 1; n <= 8; n++) begin
            tick();
            chk("ph_hphi1", int'(hphi1), int'(n % 4 == 0));
            chk("ph_hphi2", int'(hphi2), int'(n % 4 == 2));
            chk("ph_rsynl", int'(rsynl), int'(n < 2));
        end

        // Values listed P0, P1, M0, M1, BL (P0 in the low nibble).
        run_line("line_a", {4'b0010, 4'b1100, 4'b0100, 4'b0000, 4'b0111}, 0, 9, 12, -1, -1, 1);
        run_line("line_b", {4'b1011, 4'b0011, 4'b1111, 4'b1010, 4'b1000}, 0, 9, 12, -1, -1, 1);
        run_line("line_c", {4'b1001, 4'b1101, 4'b1110, 4'b0001, 4'b0101}, 0, 9, 12, -1, -1, 1);
        run_line("hmclr",  {4'b0111, 4'b0110, 4'b1000, 4'b0001, 4'b1111}, 9, 10, 12, -1, -1, 1);
        run_line("sec_held", {4'b0011, 4'b1001, 4'b0101, 4'b1110, 4'b0000}, 0, 9, 28, -1, -1, 1);

        // Small counts finish before the second edge, so a restart doubles them.
`ifdef TIA_HMOVE_RETRIGGER_EN
        run_line("retrig", {4'b1100, 4'b1011, 4'b1010, 4'b1001, 4'b1000}, 0, 9, 12, 45, 47, 2);
`else
        run_line("retrig", {4'b1100, 4'b1011, 4'b1010, 4'b1001, 4'b1000}, 0, 9, 12, 45, 47, 1);
`endif

        for (int t = 0; t < 4; t++) begin
            hmv   = 20'($urandom);
            s_on  = 6 + int'($urandom_range(14, 0));
            s_len = int'($urandom_range(19, 0));
            run_line($sformatf("rand%0d", t), hmv, 0, s_on, s_on + s_len, -1, -1, 1);
        end

        // Abort during step 5 of a full-length P0 burst.
        clear_counts();
        hit = 1'b0;
        for (int c = 0; c < 150 && !hit; c++) begin
            set_inputs(c, {4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111}, 0, 9, 12, -1, -1);
            tick();
            if (low_cnt[0] == 6 && p0ec_bar == 1'b0) hit = 1'b1;
        end
        chk("abort_reached", int'(hit), 1);
        chk("abort_pre_ec", int'(ec_vec()), 0);
        r = 1'b1;
        #1;
        chk("abort_ec", int'(ec_vec()), 31);
        chk("abort_hphi1", int'(hphi1), 0);
        chk("abort_rsynl", int'(rsynl), 1);
        repeat (2) @(posedge clk);
        #1;
        r = 1'b0;
        clear_counts();
        run_line("after_rst", {4'b0100, 4'b0011, 4'b0010, 4'b0001, 4'b0110}, 0, 9, 12, -1, -1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
